// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port synchronous data RAM between the core
// load/store unit (port 0) and the debug/loader port (port 1). Requests are
// range/alignment checked, arbitrated round-robin or fixed-priority, and each
// 1-cycle-latency response is routed back to the port that issued it.
module dmem_arbiter #(
    parameter int                ADDR_W      = 32,
    parameter int                DEPTH       = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 'h0000_1000,
    parameter bit                ROUND_ROBIN = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_p0_valid,
    output logic                     o_p0_ready,
    input  logic                     i_p0_we,
    input  logic [ADDR_W-1:0]        i_p0_addr,
    input  logic [31:0]              i_p0_wdata,
    input  logic [3:0]               i_p0_wstrb,
    output logic                     o_p0_rvalid,
    output logic [31:0]              o_p0_rdata,
    output logic                     o_p0_err,
    input  logic                     i_p1_valid,
    output logic                     o_p1_ready,
    input  logic                     i_p1_we,
    input  logic [ADDR_W-1:0]        i_p1_addr,
    input  logic [31:0]              i_p1_wdata,
    input  logic [3:0]               i_p1_wstrb,
    output logic                     o_p1_rvalid,
    output logic [31:0]              o_p1_rdata,
    output logic                     o_p1_err,
    output logic                     o_mem_en,
    output logic [3:0]               o_mem_we,
    output logic [$clog2(DEPTH)-1:0] o_mem_addr,
    output logic [31:0]              o_mem_wdata,
    input  logic [31:0]              i_mem_rdata
);

    localparam int AW = $clog2(DEPTH);

    // One extra bit so the upper bound cannot wrap at the top of the address space.
    localparam logic [ADDR_W:0] LO_ADDR = {1'b0, BASE_ADDR};
    localparam logic [ADDR_W:0] HI_ADDR = LO_ADDR + (ADDR_W+1)'(4 * DEPTH);

    logic              r_last_grant;
    logic              r_vld;
    logic              r_port;
    logic              r_we;
    logic              r_err;

    logic              w_grant;
    logic              w_ready0;
    logic              w_ready1;
    logic              w_accept;
    logic              w_we;
    logic              w_ok;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W:0]   w_addr_ext;
    logic [31:0]       w_wdata;
    logic [3:0]        w_wstrb;

    // Grant selection: lone requester wins; ties go opposite the last grant
    // in round-robin mode, otherwise port 0 always wins.
    always_comb begin
        w_grant = 1'b0;
        if (i_p0_valid && i_p1_valid) begin
            w_grant = ROUND_ROBIN ? ~r_last_grant : 1'b0;
        end else if (i_p1_valid) begin
            w_grant = 1'b1;
        end
    end

    // Ready is forced low while reset is held so nothing reaches the RAM.
    assign w_ready0 = i_rst_n & i_p0_valid & ~w_grant;
    assign w_ready1 = i_rst_n & i_p1_valid &  w_grant;
    assign w_accept = w_ready0 | w_ready1;

    assign o_p0_ready = w_ready0;
    assign o_p1_ready = w_ready1;

    assign w_we    = w_grant ? i_p1_we    : i_p0_we;
    assign w_addr  = w_grant ? i_p1_addr  : i_p0_addr;
    assign w_wdata = w_grant ? i_p1_wdata : i_p0_wdata;
    assign w_wstrb = w_grant ? i_p1_wstrb : i_p0_wstrb;

    assign w_addr_ext = {1'b0, w_addr};
    assign w_ok       = (w_addr[1:0] == 2'b00) && (w_addr_ext >= LO_ADDR) && (w_addr_ext < HI_ADDR);

    // Rejected accesses never touch the RAM.
    assign o_mem_en    = w_accept & w_ok;
    assign o_mem_we    = (w_accept & w_ok & w_we) ? w_wstrb : 4'b0000;
    assign o_mem_addr  = AW'((w_addr - BASE_ADDR) >> 2);
    assign o_mem_wdata = w_wdata;

    // Round-robin pointer only moves when a request is actually accepted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_last_grant <= w_grant;
        end
    end

    // Response stage: remembers who was served and how, lined up with RAM read data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld  <= 1'b0;
            r_port <= 1'b0;
            r_we   <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_vld <= w_accept;
            if (w_accept) begin
                r_port <= w_grant;
                r_we   <= w_we;
                r_err  <= ~w_ok;
            end
        end
    end

    assign o_p0_rvalid = r_vld & ~r_port;
    assign o_p1_rvalid = r_vld &  r_port;
    assign o_p0_err    = o_p0_rvalid & r_err;
    assign o_p1_err    = o_p1_rvalid & r_err;
    assign o_p0_rdata  = (o_p0_rvalid & ~r_we & ~r_err) ? i_mem_rdata : 32'h0;
    assign o_p1_rdata  = (o_p1_rvalid & ~r_we & ~r_err) ? i_mem_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, hand-written
// contention/reset sequences and a randomized run against a byte-level model.
module tb_dmem_arbiter;

    localparam int DEPTH = 1024;

    typedef struct {
        logic        v0;
        logic        we0;
        logic [31:0] a0;
        logic [31:0] wd0;
        logic [3:0]  st0;
        logic        v1;
        logic        we1;
        logic [31:0] a1;
        logic [31:0] wd1;
        logic [3:0]  st1;
        logic        er0;
        logic        er1;
        logic        eme;
        logic [3:0]  emwe;
        logic [9:0]  emaddr;
        logic        erv0;
        logic        erv1;
        logic        eerr;
        logic [31:0] erd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_valid, p0_we, p1_valid, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [3:0]  p0_wstrb, p1_wstrb;
    logic        p0_ready, p0_rvalid, p0_err, p1_ready, p1_rvalid, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    logic        fp_p0_ready, fp_p0_rvalid, fp_p0_err, fp_p1_ready, fp_p1_rvalid, fp_p1_err;
    logic [31:0] fp_p0_rdata, fp_p1_rdata, fp_mem_wdata;
    logic        fp_mem_en;
    logic [3:0]  fp_mem_we;
    logic [9:0]  fp_mem_addr;

    logic [31:0] ram [DEPTH] = '{default: 32'h0};
    logic [7:0]  ref_bytes [4*DEPTH] = '{default: 8'h0};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ROUND_ROBIN(1'b1)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_p0_valid(p0_valid), .o_p0_ready(p0_ready), .i_p0_we(p0_we), .i_p0_addr(p0_addr),
        .i_p0_wdata(p0_wdata), .i_p0_wstrb(p0_wstrb), .o_p0_rvalid(p0_rvalid),
        .o_p0_rdata(p0_rdata), .o_p0_err(p0_err),
        .i_p1_valid(p1_valid), .o_p1_ready(p1_ready), .i_p1_we(p1_we), .i_p1_addr(p1_addr),
        .i_p1_wdata(p1_wdata), .i_p1_wstrb(p1_wstrb), .o_p1_rvalid(p1_rvalid),
        .o_p1_rdata(p1_rdata), .o_p1_err(p1_err),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.ROUND_ROBIN(1'b0)) u_fp (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_p0_valid(p0_valid), .o_p0_ready(fp_p0_ready), .i_p0_we(p0_we), .i_p0_addr(p0_addr),
        .i_p0_wdata(p0_wdata), .i_p0_wstrb(p0_wstrb), .o_p0_rvalid(fp_p0_rvalid),
        .o_p0_rdata(fp_p0_rdata), .o_p0_err(fp_p0_err),
        .i_p1_valid(p1_valid), .o_p1_ready(fp_p1_ready), .i_p1_we(p1_we), .i_p1_addr(p1_addr),
        .i_p1_wdata(p1_wdata), .i_p1_wstrb(p1_wstrb), .o_p1_rvalid(fp_p1_rvalid),
        .o_p1_rdata(fp_p1_rdata), .o_p1_err(fp_p1_err),
        .o_mem_en(fp_mem_en), .o_mem_we(fp_mem_we), .o_mem_addr(fp_mem_addr),
        .o_mem_wdata(fp_mem_wdata), .i_mem_rdata(32'h0)
    );

    // Synchronous single-port RAM behind the round-robin instance.
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= ram[mem_addr];
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic v0, input logic we0, input logic [31:0] a0,
                          input logic [31:0] wd0, input logic [3:0] st0,
                          input logic v1, input logic we1, input logic [31:0] a1,
                          input logic [31:0] wd1, input logic [3:0] st1);
        p0_valid = v0; p0_we = we0; p0_addr = a0; p0_wdata = wd0; p0_wstrb = st0;
        p1_valid = v1; p1_we = we1; p1_addr = a1; p1_wdata = wd1; p1_wstrb = st1;
    endtask

    function automatic bit addr_ok(input logic [31:0] a);
        longint la;
        la = longint'(a);
        return (la % 4 == 0) && (la >= 64'h1000) && (la < 64'h1000 + 4 * DEPTH);
    endfunction

    vec_t vecs [13];

    // Random-phase model state
    int          m_last;
    int          g;
    bit          pend [2];
    bit          pwe  [2];
    logic [31:0] paddr [2];
    logic [31:0] pwd  [2];
    logic [3:0]  pst  [2];
    bit          n_vld, n_err;
    int          n_port;
    logic [31:0] n_rd;
    int          off;

    initial begin
        vecs[0]  = '{1,1,32'h1004,32'hDEADBEEF,4'hF, 0,0,0,0,0,     1,0,1,4'hF,10'd1,    1,0,0,32'h0};
        vecs[1]  = '{1,0,32'h1004,0,0,             0,0,0,0,0,     1,0,1,4'h0,10'd1,    1,0,0,32'hDEADBEEF};
        vecs[2]  = '{0,0,0,0,0,                    1,0,32'h0FFC,0,0, 0,1,0,4'h0,10'd0, 0,1,1,32'h0};
        vecs[3]  = '{1,0,32'h2000,0,0,             0,0,0,0,0,     1,0,0,4'h0,10'd0,    1,0,1,32'h0};
        vecs[4]  = '{0,0,0,0,0,                    1,1,32'h1FFC,32'hCAFEF00D,4'hF, 0,1,1,4'hF,10'd1023, 0,1,0,32'h0};
        vecs[5]  = '{1,0,32'h1002,0,0,             0,0,0,0,0,     1,0,0,4'h0,10'd0,    1,0,1,32'h0};
        vecs[6]  = '{0,0,0,0,0,                    1,1,32'h1008,32'hAABBCCDD,4'hF, 0,1,1,4'hF,10'd2, 0,1,0,32'h0};
        vecs[7]  = '{1,1,32'h1008,32'h11223344,4'b0101, 0,0,0,0,0, 1,0,1,4'b0101,10'd2, 1,0,0,32'h0};
        vecs[8]  = '{0,0,0,0,0,                    1,0,32'h1008,0,0, 0,1,1,4'h0,10'd2,  0,1,0,32'hAA22CC44};
        vecs[9]  = '{0,0,0,0,0,                    1,0,32'h1FFC,0,0, 0,1,1,4'h0,10'd1023, 0,1,0,32'hCAFEF00D};
        vecs[10] = '{1,0,32'h1004,0,0,             1,0,32'h1008,0,0, 1,0,1,4'h0,10'd1,  1,0,0,32'hDEADBEEF};
        vecs[11] = '{0,0,0,0,0,                    1,0,32'h1008,0,0, 0,1,1,4'h0,10'd2,  0,1,0,32'hAA22CC44};
        vecs[12] = '{0,0,0,0,0,                    1,1,32'h2000,32'hFFFFFFFF,4'hF, 0,1,0,4'h0,10'd0, 0,1,1,32'h0};

        // Reset held with a pending port-0 request
        rst_n = 1'b0;
        set_in(1, 0, 32'h1000, 0, 0, 0, 0, 0, 0, 0);
        repeat (5) begin
            #2;
            chk("rst_p0_ready", 32'(p0_ready), 0);
            chk("rst_p1_ready", 32'(p1_ready), 0);
            chk("rst_mem_en", 32'(mem_en), 0);
            chk("rst_mem_we", 32'(mem_we), 0);
            @(posedge clk); #1;
            chk("rst_p0_rvalid", 32'(p0_rvalid), 0);
            chk("rst_p1_rvalid", 32'(p1_rvalid), 0);
            chk("rst_p0_rdata", p0_rdata, 0);
        end
        rst_n = 1'b1;
        #2;
        chk("rel_p0_ready", 32'(p0_ready), 1);
        chk("rel_mem_en", 32'(mem_en), 1);
        chk("rel_mem_addr", 32'(mem_addr), 0);
        @(posedge clk); #1;
        chk("rel_p0_rvalid", 32'(p0_rvalid), 1);
        chk("rel_p0_rdata", p0_rdata, 0);

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            set_in(vecs[i].v0, vecs[i].we0, vecs[i].a0, vecs[i].wd0, vecs[i].st0,
                   vecs[i].v1, vecs[i].we1, vecs[i].a1, vecs[i].wd1, vecs[i].st1);
            #2;
            chk($sformatf("v%0d_ready0", i), 32'(p0_ready), 32'(vecs[i].er0));
            chk($sformatf("v%0d_ready1", i), 32'(p1_ready), 32'(vecs[i].er1));
            chk($sformatf("v%0d_mem_en", i), 32'(mem_en), 32'(vecs[i].eme));
            chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].emwe));
            if (vecs[i].eme) chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].emaddr));
            @(posedge clk); #1;
            chk($sformatf("v%0d_rvalid0", i), 32'(p0_rvalid), 32'(vecs[i].erv0));
            chk($sformatf("v%0d_rvalid1", i), 32'(p1_rvalid), 32'(vecs[i].erv1));
            chk($sformatf("v%0d_err0", i), 32'(p0_err), 32'(vecs[i].erv0 & vecs[i].eerr));
            chk($sformatf("v%0d_err1", i), 32'(p1_err), 32'(vecs[i].erv1 & vecs[i].eerr));
            chk($sformatf("v%0d_rdata0", i), p0_rdata, vecs[i].erv0 ? vecs[i].erd : 32'h0);
            chk($sformatf("v%0d_rdata1", i), p1_rdata, vecs[i].erv1 ? vecs[i].erd : 32'h0);
        end

        // Continuous contention: round-robin alternates, fixed priority starves port 1
        for (int i = 0; i < 6; i++) begin
            set_in(1, 0, 32'h1004, 0, 0, 1, 0, 32'h1008, 0, 0);
            #2;
            chk($sformatf("rr%0d_ready0", i), 32'(p0_ready), 32'(i % 2 == 0));
            chk($sformatf("rr%0d_ready1", i), 32'(p1_ready), 32'(i % 2 == 1));
            chk($sformatf("fp%0d_ready0", i), 32'(fp_p0_ready), 1);
            chk($sformatf("fp%0d_ready1", i), 32'(fp_p1_ready), 0);
            @(posedge clk); #1;
            chk($sformatf("rr%0d_rvalid0", i), 32'(p0_rvalid), 32'(i % 2 == 0));
            chk($sformatf("rr%0d_rvalid1", i), 32'(p1_rvalid), 32'(i % 2 == 1));
            if (i % 2 == 0) chk($sformatf("rr%0d_rdata0", i), p0_rdata, 32'hDEADBEEF);
            else            chk($sformatf("rr%0d_rdata1", i), p1_rdata, 32'hAA22CC44);
        end

        // Make port 0 the last winner, then kill a port-1 accept with reset
        set_in(1, 0, 32'h1004, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("pre_rst_rdata0", p0_rdata, 32'hDEADBEEF);
        set_in(0, 0, 0, 0, 0, 1, 0, 32'h1004, 0, 0);
        #2;
        chk("mid_ready1_pre", 32'(p1_ready), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_ready1_rst", 32'(p1_ready), 0);
        chk("mid_mem_en_rst", 32'(mem_en), 0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("mid_p1_rvalid", 32'(p1_rvalid), 0);
            chk("mid_p0_rvalid", 32'(p0_rvalid), 0);
        end
        set_in(1, 0, 32'h1004, 0, 0, 1, 0, 32'h1008, 0, 0);
        rst_n = 1'b1;
        #2;
        chk("post_tie_ready0", 32'(p0_ready), 1);
        chk("post_tie_ready1", 32'(p1_ready), 0);
        @(posedge clk); #1;
        chk("post_tie_rvalid0", 32'(p0_rvalid), 1);
        chk("post_tie_rvalid1", 32'(p1_rvalid), 0);
        chk("post_tie_rdata0", p0_rdata, 32'hDEADBEEF);

        // Fresh start for the randomized run
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_last = 1;
        pend[0] = 0; pend[1] = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 9) < 6) begin
                    pend[p] = 1;
                    pwe[p]  = 1'($urandom_range(0, 1));
                    case ($urandom_range(0, 9))
                        7:       paddr[p] = 32'h0FFC;
                        8:       paddr[p] = 32'h2000 + 4 * $urandom_range(0, 3);
                        9:       paddr[p] = 32'h1100 + $urandom_range(1, 3);
                        default: paddr[p] = 32'h1100 + 4 * $urandom_range(0, 15);
                    endcase
                    pwd[p] = $urandom;
                    pst[p] = 4'($urandom_range(0, 15));
                end
            end
            set_in(pend[0], pwe[0], paddr[0], pwd[0], pst[0], pend[1], pwe[1], paddr[1], pwd[1], pst[1]);
            if (pend[0] && pend[1]) g = 1 - m_last;
            else if (pend[0])       g = 0;
            else if (pend[1])       g = 1;
            else                    g = -1;
            #2;
            chk("rnd_ready0", 32'(p0_ready), 32'(g == 0));
            chk("rnd_ready1", 32'(p1_ready), 32'(g == 1));
            n_vld = 0; n_err = 0; n_port = 0; n_rd = 0;
            if (g >= 0) begin
                n_vld  = 1;
                n_port = g;
                n_err  = !addr_ok(paddr[g]);
                chk("rnd_mem_en", 32'(mem_en), 32'(!n_err));
                if (!n_err) begin
                    off = int'(paddr[g] - 32'h1000);
                    chk("rnd_mem_addr", 32'(mem_addr), 32'(off / 4));
                    chk("rnd_mem_we", 32'(mem_we), pwe[g] ? 32'(pst[g]) : 32'h0);
                    if (pwe[g]) begin
                        for (int b = 0; b < 4; b++)
                            if (pst[g][b]) ref_bytes[off + b] = pwd[g][8*b +: 8];
                    end else begin
                        n_rd = {ref_bytes[off+3], ref_bytes[off+2], ref_bytes[off+1], ref_bytes[off]};
                    end
                end
                m_last  = g;
                pend[g] = 0;
            end else begin
                chk("rnd_mem_en_idle", 32'(mem_en), 0);
            end
            @(posedge clk); #1;
            chk("rnd_rvalid0", 32'(p0_rvalid), 32'(n_vld && n_port == 0));
            chk("rnd_rvalid1", 32'(p1_rvalid), 32'(n_vld && n_port == 1));
            chk("rnd_err0", 32'(p0_err), 32'(n_vld && n_port == 0 && n_err));
            chk("rnd_err1", 32'(p1_err), 32'(n_vld && n_port == 1 && n_err));
            chk("rnd_rdata0", p0_rdata, (n_vld && n_port == 0) ? n_rd : 32'h0);
            chk("rnd_rdata1", p1_rdata, (n_vld && n_port == 1) ? n_rd : 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data RAM between two requesters: port 0 is the core load/store unit, port 1 is the debug/loader port.
- Arbitrates accepted requests round-robin, or fixed-priority when configured.
- Range- and alignment-checks byte addresses and routes each 1-cycle-latency response back to the requester that issued it.
- Sits between the core/debug logic and the data memory inside toplevel.

Parameters:
- ADDR_W, 32, byte-address width of requester ports.
- DEPTH, 1024, RAM depth in 32-bit words; must be a power of two.
- BASE_ADDR, 32'h0000_1000, byte address of RAM word 0.
- ROUND_ROBIN, 1, 1 = round-robin arbitration, 0 = port 0 always wins.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- p0_valid / p1_valid  in  1  request valid.
- p0_ready / p1_ready  out  1  request accepted this cycle.
- p0_we / p1_we  in  1  1 = write, 0 = read.
- p0_addr / p1_addr  in  ADDR_W  byte address.
- p0_wdata / p1_wdata  in  32  write data.
- p0_wstrb / p1_wstrb  in  4  byte enables for writes.
- p0_rvalid / p1_rvalid  out  1  response valid, one cycle after acceptance.
- p0_rdata / p1_rdata  out  32  read data; 0 for writes and errors.
- p0_err / p1_err  out  1  qualifies rvalid; out-of-range or misaligned access.
- mem_en  out  1  RAM access enable.
- mem_we  out  4  RAM byte write enables.
- mem_addr  out  log2(DEPTH)  RAM word index.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data; valid the cycle after mem_en.

Behaviour:
- Reset (async, rst_n=0):
  - All rvalid/err = 0 and all rdata = 0.
  - last_grant = 1, so port 0 wins the first tie.
  - Any in-flight response is dropped.
  - During reset, ready outputs are 0 and mem_en/mem_we = 0.
- Grant is combinational from valid inputs and the registered last_grant:
  - Only p0_valid: grant 0. Only p1_valid: grant 1.
  - Both valid, ROUND_ROBIN=1: grant = ~last_grant.
  - Both valid, ROUND_ROBIN=0: grant 0.
  - pX_ready = pX_valid & (grant == X). At most one ready high per cycle.
  - Requesters must hold valid and payload stable until ready.
- Acceptance: accept = valid & ready. On accept, last_grant <= granted port. last_grant does not change when nothing is accepted.
- Address check: ok = (addr[1:0] == 0) & (addr >= BASE_ADDR) & (addr < BASE_ADDR + 4*DEPTH). Compare at ADDR_W+1 bits, so no wrap at the top of the address space.
- Memory drive:
  - mem_en = accept & ok.
  - mem_we = (accept & ok & we) ? wstrb : 4'b0.
  - mem_addr = (addr - BASE_ADDR) >> 2.
  - mem_wdata = wdata.
  - Memory outputs are combinational and unregistered.
  - Rejected (not ok) accesses never assert mem_en.
- Response pipeline: one register stage holding {vld, port, we, err}.
  - The cycle after an accept, rvalid for that port = 1 and all other rvalid = 0.
  - err = ~ok.
  - rdata = (~we & ~err) ? mem_rdata : 0.
  - Writes return rvalid with rdata = 0 (write ack).
- Throughput: one accept per cycle, back-to-back. The response for cycle N's accept coexists with a new accept in cycle N+1. No stalling on the response side: requesters must always sink rvalid.
- Simultaneous: under continuous contention with ROUND_ROBIN=1, grants alternate 0,1,0,1. With ROUND_ROBIN=0, port 1 starves while p0_valid stays high (documented, intended).
- Reset asserted mid-transaction: the pending response is discarded and no rvalid is issued. Requesters re-issue after reset.

Test Plan:
- Reset value check: assert rst_n=0 for 5 cycles with p0_valid=1 -> all ready, rvalid, mem_en and rdata are 0. Release -> first cycle p0_ready=1.
- Port 0 write then read: write addr 32'h1004, wdata 32'hDEADBEEF, wstrb 4'hF -> mem_addr=1, mem_we=4'hF, next cycle p0_rvalid=1, p0_err=0, p0_rdata=0. Read the same address -> next cycle p0_rdata=32'hDEADBEEF.
- Contention with ROUND_ROBIN=1: both ports hold valid for 6 reads -> grants 0,1,0,1,0,1. Each rvalid lands on the correct port exactly one cycle after its accept. With ROUND_ROBIN=0 -> six consecutive port-0 grants and p1_ready stays 0.
- Error paths:
  - addr 32'h0FFC -> err=1, mem_en=0.
  - addr 32'h2000 (BASE + 4*1024) -> err=1.
  - addr 32'h1FFC -> err=0, mem_addr=1023.
  - addr 32'h1002 -> err=1. Every error response has rdata=0.
- Byte strobe: write 32'h11223344 with wstrb 4'b0101 to 32'h1008 -> mem_we=4'b0101. Subsequent read against the bench RAM model returns 32'hxx22xx44 with the previous bytes preserved.
- Reset mid-operation: accept a port 1 read, then drop rst_n in the same cycle before the clock edge -> no p1_rvalid ever asserts. After release, last_grant=1 and port 0 wins the first tie.
